ram16_arbiter: RTL

- Two-requester arbiter and sequencer for the 16-word x 32-bit single-port distributed RAM: synchronous write, combinational read.
- Shares the RAM between m0 (CPU data side) and m1 (debug/loader side).
- Accepts one access per cycle using round-robin or fixed priority.
- Returns read data registered, one cycle after grant.
- Optionally sweeps the RAM to a known value after reset.

---
 rtl/ram16_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ram16_arbiter.sv
// Two-requester arbiter/sequencer for a 16x32 single-port RAM with sync write and comb read.
// Optional post-reset clear sweep enabled by defining RAM16_CLEAR_EN.
module ram16_arbiter #(
  parameter int unsigned ARB_MODE    = 0,
  parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [3:0]  ram_ad,
  output logic [31:0] ram_di,
  output logic        ram_wre,
  input  logic [31:0] ram_dout,
  output logic        busy
);

  typedef enum logic {CLEAR, RUN} state_t;

`ifdef RAM16_CLEAR_EN
  localparam state_t START_STATE = CLEAR;
`else
  localparam state_t START_STATE = RUN;
`endif

  state_t      state;
  logic [3:0]  clr_cnt;
  logic        last_gnt;   // 0 = m0 was granted last, 1 = m1
  logic [3:0]  ad_q;
  logic [31:0] di_q;
  logic        run;
  logic        sweep;
  logic        sel0;
  logic        sel1;

  always_comb begin
    run   = !rst && (state == RUN);
    sweep = !rst && (state == CLEAR);
    sel0  = 1'b0;
    sel1  = 1'b0;
    if (run) begin
      if (m0_req && m1_req) begin
        if (ARB_MODE == 1 || last_gnt) sel0 = 1'b1;
        else                           sel1 = 1'b1;
      end else begin
        sel0 = m0_req;
        sel1 = m1_req;
      end
    end
  end

  // RAM port follows the winner; with no access it keeps the last driven address/data.
  always_comb begin
    m0_gnt  = sel0;
    m1_gnt  = sel1;
    ram_wre = 1'b0;
    ram_ad  = ad_q;
    ram_di  = di_q;
    if (rst) begin
      ram_ad = '0;
      ram_di = '0;
    end else if (sweep) begin
      ram_ad  = clr_cnt;
      ram_di  = CLEAR_VALUE;
      ram_wre = 1'b1;
    end else if (sel0) begin
      ram_ad  = m0_addr;
      ram_di  = m0_wdata;
      ram_wre = m0_we;
    end else if (sel1) begin
      ram_ad  = m1_addr;
      ram_di  = m1_wdata;
      ram_wre = m1_we;
    end
  end

`ifdef RAM16_CLEAR_EN
  always_comb busy = (state == CLEAR);
`else
  always_comb busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= START_STATE;
      clr_cnt   <= '0;
      last_gnt  <= 1'b1;
      ad_q      <= '0;
      di_q      <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        CLEAR: begin
          ad_q    <= clr_cnt;
          di_q    <= CLEAR_VALUE;
          clr_cnt <= clr_cnt + 4'd1;
          if (clr_cnt == 4'hF) state <= RUN;
        end
        default: begin
          if (sel0) begin
            last_gnt <= 1'b0;
            ad_q     <= m0_addr;
            di_q     <= m0_wdata;
            if (!m0_we) begin
              m0_rdata  <= ram_dout;
              m0_rvalid <= 1'b1;
            end
          end else if (sel1) begin
            last_gnt <= 1'b1;
            ad_q     <= m1_addr;
            di_q     <= m1_wdata;
            if (!m1_we) begin
              m1_rdata  <= ram_dout;
              m1_rvalid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
